int_to_float: RTL and testbench

INT_TO_FLOAT -- requirements
Module: int_to_float

---
 rtl/int_to_float.sv | 131 +++++++++++++
 tb/tb_int_to_float.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single converter.
// Normalises one bit per cycle, rounds to nearest-even, handshakes on both sides.
module int_to_float (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [2:0] {
      GET_A, CONVERT_0, NORMALISE, ROUND, PACK, PUT_Z
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] value_q, value_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic [22:0] m_q, m_d;
   logic        ack_q, ack_d;
   logic [31:0] z_q, z_d;
   logic        stb_q, stb_d;

   logic        guard, sticky;
   logic [24:0] m_inc;

   assign guard  = value_q[7];
   assign sticky = |value_q[6:0];
   assign m_inc  = {1'b0, value_q[31:8]} + 25'd1;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      value_d = value_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      m_d     = m_q;
      ack_d   = ack_q;
      z_d     = z_q;
      stb_d   = stb_q;
      case (state_q)
         GET_A: begin
            ack_d = 1'b1;
            if (input_a_stb && ack_q) begin
               a_d     = input_a;
               ack_d   = 1'b0;
               state_d = CONVERT_0;
            end
         end
         CONVERT_0: begin
            if (a_q == 32'd0) begin
               z_d     = 32'd0;
               stb_d   = 1'b1;
               state_d = PUT_Z;
            end else begin
               // Two's-complement negate; 0x80000000 maps onto itself as unsigned 2^31.
               sign_d  = a_q[31];
               value_d = a_q[31] ? (~a_q + 32'd1) : a_q;
               exp_d   = 8'd31;
               state_d = NORMALISE;
            end
         end
         NORMALISE: begin
            if (value_q[31]) begin
               state_d = ROUND;
            end else begin
               value_d = value_q << 1;
               exp_d   = exp_q - 8'd1;
            end
         end
         ROUND: begin
            m_d = value_q[30:8];
            if (guard && (sticky || value_q[8])) begin
               // Carry out of 24 bits leaves the hidden 1 with a zero fraction.
               if (m_inc[24]) begin
                  m_d   = 23'd0;
                  exp_d = exp_q + 8'd1;
               end else begin
                  m_d = m_inc[22:0];
               end
            end
            state_d = PACK;
         end
         PACK: begin
            z_d     = {sign_q, exp_q + 8'd127, m_q};
            stb_d   = 1'b1;
            state_d = PUT_Z;
         end
         PUT_Z: begin
            if (output_z_ack) begin
               stb_d   = 1'b0;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GET_A;
         a_q     <= '0;
         value_q <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         m_q     <= '0;
         ack_q   <= 1'b0;
         z_q     <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         value_q <= value_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         m_q     <= m_d;
         ack_q   <= ack_d;
         z_q     <= z_d;
         stb_q   <= stb_d;
      end
   end

   assign input_a_ack  = ack_q;
   assign output_z     = z_q;
   assign output_z_stb = stb_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed corner cases, backpressure,
// mid-conversion reset and randomized operands against an arithmetic reference.
module tb_int_to_float;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] input_a = '0;
   logic        input_a_stb = 1'b0;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   int_to_float dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int ref_msb(input logic [31:0] a);
      longint mag = longint'($signed(a));
      int     msb = 0;
      if (mag < 0) mag = -mag;
      while ((mag >> (msb + 1)) != 0) msb++;
      return msb;
   endfunction

   // Magnitude, leading-one position, then nearest-even via remainder vs. half.
   function automatic logic [31:0] ref_f(input logic [31:0] a);
      longint mag, q, rem, half;
      int     msb, s, e;
      logic   sg;
      if (a == 32'd0) return 32'd0;
      sg  = a[31];
      mag = longint'($signed(a));
      if (mag < 0) mag = -mag;
      msb = ref_msb(a);
      e   = msb;
      if (msb <= 23) begin
         q = mag << (23 - msb);
      end else begin
         s    = msb - 23;
         q    = mag >> s;
         rem  = mag - (q << s);
         half = longint'(1) << (s - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e++;
         end
      end
      return {sg, 8'(e + 127), q[22:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] a);
      return (a == 32'd0) ? 1 : 4 + 31 - ref_msb(a);
   endfunction

   // Offer one operand, measure latency, hold result ack_dly cycles, then release.
   task automatic do_op(input logic [31:0] a, input int idle, input int ack_dly);
      int n;
      logic [31:0] z0;
      repeat (idle) @(negedge clk);
      n = 0;
      while (!input_a_ack && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("ack_ready", {31'd0, input_a_ack}, 32'd1);
      input_a     = a;
      input_a_stb = 1'b1;
      @(negedge clk);
      input_a_stb = 1'b0;
      input_a     = $urandom;
      n = 0;
      while (!output_z_stb && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("lat_%h", a), 32'(n), 32'(ref_lat(a)));
      chk($sformatf("z_%h", a), output_z, ref_f(a));
      z0 = output_z;
      repeat (ack_dly) @(negedge clk);
      if (ack_dly > 0) begin
         chk("hold_z", output_z, z0);
         chk("hold_stb", {31'd0, output_z_stb}, 32'd1);
      end
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      chk("stb_fall", {31'd0, output_z_stb}, 32'd0);
   endtask

   initial begin
      logic [31:0] dir [7];
      logic [31:0] a, z0;
      dir = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
              32'h01000001, 32'h01000003, 32'h7FFFFFFF};

      repeat (3) @(negedge clk);
      chk("rst_ack", {31'd0, input_a_ack}, 32'd0);
      chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
      chk("rst_z", output_z, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ack_after_rst", {31'd0, input_a_ack}, 32'd1);

      foreach (dir[i]) do_op(dir[i], 0, 1);
      chk("spec_1", ref_f(32'h00000001), 32'h3F800000);
      chk("spec_tie", ref_f(32'h01000001), 32'h4B800000);
      chk("spec_carry", ref_f(32'h7FFFFFFF), 32'h4F000000);

      // Backpressure: result held 50 cycles while a new offer is ignored.
      input_a     = 32'h00012345;
      input_a_stb = 1'b1;
      while (!input_a_ack) @(negedge clk);
      @(negedge clk);
      input_a = 32'h00000007;
      for (int n = 0; n < 100 && !output_z_stb; n++) @(negedge clk);
      z0 = output_z;
      chk("bp_z", z0, ref_f(32'h00012345));
      repeat (50) begin
         @(negedge clk);
         chk("bp_hold_z", output_z, z0);
         chk("bp_hold_stb", {31'd0, output_z_stb}, 32'd1);
         chk("bp_ack_low", {31'd0, input_a_ack}, 32'd0);
      end
      input_a_stb  = 1'b0;
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      chk("bp_stb_fall", {31'd0, output_z_stb}, 32'd0);
      chk("bp_ack_still_low", {31'd0, input_a_ack}, 32'd0);
      @(negedge clk);
      chk("bp_ack_rise", {31'd0, input_a_ack}, 32'd1);

      // Reset during NORMALISE of a=1 discards the conversion.
      input_a     = 32'h00000001;
      input_a_stb = 1'b1;
      @(negedge clk);
      input_a_stb = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_stb", {31'd0, output_z_stb}, 32'd0);
      @(negedge clk);
      chk("mid_rst_ack", {31'd0, input_a_ack}, 32'd1);
      begin
         logic seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (output_z_stb) seen = 1'b1;
         end
         chk("mid_rst_no_stb", {31'd0, seen}, 32'd0);
      end
      do_op(32'h00000005, 0, 0);
      chk("spec_5", ref_f(32'h00000005), 32'h40A00000);

      for (int i = 0; i < 1000; i++) begin
         a = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) a = -a;
         if ($urandom_range(0, 15) == 0) a = 32'h00FFFFFF + 32'($urandom_range(0, 4));
         do_op(a, $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
